// File: rtl/reg_read_scoreboard.sv
// Register file with a pending-write scoreboard; issue_ready stalls a read until its sources are clean.
// Operands appear one cycle after fire; a same-cycle write-back can optionally be forwarded to the read.
module reg_read_scoreboard #(
  parameter bit BYPASS = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        issue_valid,
  output logic        issue_ready,
  input  logic [4:0]  rs_addr,
  input  logic [4:0]  rt_addr,
  input  logic        dest_en,
  input  logic [4:0]  dest_addr,
  input  logic        wb_en,
  input  logic [4:0]  wb_addr,
  input  logic [31:0] wb_data,
  input  logic        flush,
  output logic        out_valid,
  output logic [31:0] rs_data,
  output logic [31:0] rt_data,
  output logic [5:0]  pending_count
);

  logic [31:0] regs_q [32];
  logic [31:0] pending_q, pending_d;
  logic        out_valid_q, out_valid_d;
  logic [31:0] rs_data_q, rs_data_d;
  logic [31:0] rt_data_q, rt_data_d;
  logic [5:0]  count_q, count_d;

  logic        wr_en;
  logic        rs_fwd, rt_fwd;
  logic        rs_haz, rt_haz;
  logic [31:0] rs_val, rt_val;
  logic        fire;

  assign wr_en = wb_en && (wb_addr != 5'd0);

  // Forwarding never applies to r0: it reads 0 whatever is being written back.
  assign rs_fwd = BYPASS && wr_en && (wb_addr == rs_addr);
  assign rt_fwd = BYPASS && wr_en && (wb_addr == rt_addr);

  assign rs_haz = (rs_addr != 5'd0) && pending_q[rs_addr] && !rs_fwd;
  assign rt_haz = (rt_addr != 5'd0) && pending_q[rt_addr] && !rt_fwd;

  assign issue_ready = !rs_haz && !rt_haz;
  assign fire        = issue_valid && issue_ready && !flush;

  always_comb begin
    rs_val = regs_q[rs_addr];
    rt_val = regs_q[rt_addr];
    if (rs_fwd) rs_val = wb_data;
    if (rt_fwd) rt_val = wb_data;
    if (rs_addr == 5'd0) rs_val = '0;
    if (rt_addr == 5'd0) rt_val = '0;
  end

  always_comb begin
    pending_d   = pending_q;
    out_valid_d = fire;
    rs_data_d   = rs_data_q;
    rt_data_d   = rt_data_q;
    count_d     = '0;
    if (fire) begin
      rs_data_d = rs_val;
      rt_data_d = rt_val;
    end
    if (flush) begin
      pending_d = '0;
    end else begin
      // Clear before set so an issue claiming the register being retired keeps it pending.
      if (wr_en) pending_d[wb_addr] = 1'b0;
      if (fire && dest_en && (dest_addr != 5'd0)) pending_d[dest_addr] = 1'b1;
    end
    for (int i = 1; i < 32; i++) begin
      count_d = count_d + {5'd0, pending_d[i]};
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) regs_q[i] <= '0;
      pending_q   <= '0;
      out_valid_q <= 1'b0;
      rs_data_q   <= '0;
      rt_data_q   <= '0;
      count_q     <= '0;
    end else begin
      if (wr_en) regs_q[wb_addr] <= wb_data;
      pending_q   <= pending_d;
      out_valid_q <= out_valid_d;
      rs_data_q   <= rs_data_d;
      rt_data_q   <= rt_data_d;
      count_q     <= count_d;
    end
  end

  assign out_valid     = out_valid_q;
  assign rs_data       = rs_data_q;
  assign rt_data       = rt_data_q;
  assign pending_count = count_q;

endmodule

// File: tb/tb_reg_read_scoreboard.sv
// Directed bench: u_a (forwarding) is checked through an operand scoreboard, u_b (no forwarding) on the stall timing.
module tb_reg_read_scoreboard;

  logic        clock = 1'b0;
  logic        reset;

  logic        issue_valid, issue_ready, dest_en, wb_en, flush, out_valid;
  logic [4:0]  rs_addr, rt_addr, dest_addr, wb_addr;
  logic [31:0] wb_data, rs_data, rt_data;
  logic [5:0]  pending_count;

  logic        b_issue_valid, b_issue_ready, b_dest_en, b_wb_en, b_flush, b_out_valid;
  logic [4:0]  b_rs_addr, b_rt_addr, b_dest_addr, b_wb_addr;
  logic [31:0] b_wb_data, b_rs_data, b_rt_data;
  logic [5:0]  b_pending_count;

  int          total = 0;
  int          bad   = 0;
  logic [63:0] sb_q[$];
  logic        exp_fire;

  always #5 clock = ~clock;

  reg_read_scoreboard #(.BYPASS(1'b1)) u_a (
    .clock(clock), .reset(reset),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .rs_addr(rs_addr), .rt_addr(rt_addr),
    .dest_en(dest_en), .dest_addr(dest_addr),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .flush(flush),
    .out_valid(out_valid), .rs_data(rs_data), .rt_data(rt_data),
    .pending_count(pending_count)
  );

  reg_read_scoreboard #(.BYPASS(1'b0)) u_b (
    .clock(clock), .reset(reset),
    .issue_valid(b_issue_valid), .issue_ready(b_issue_ready),
    .rs_addr(b_rs_addr), .rt_addr(b_rt_addr),
    .dest_en(b_dest_en), .dest_addr(b_dest_addr),
    .wb_en(b_wb_en), .wb_addr(b_wb_addr), .wb_data(b_wb_data),
    .flush(b_flush),
    .out_valid(b_out_valid), .rs_data(b_rs_data), .rt_data(b_rt_data),
    .pending_count(b_pending_count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    issue_valid = 0; rs_addr = 0; rt_addr = 0; dest_en = 0; dest_addr = 0;
    wb_en = 0; wb_addr = 0; wb_data = 0; flush = 0;
    b_issue_valid = 0; b_rs_addr = 0; b_rt_addr = 0; b_dest_en = 0; b_dest_addr = 0;
    b_wb_en = 0; b_wb_addr = 0; b_wb_data = 0; b_flush = 0;
  endtask

  task automatic expect_fire(input logic [31:0] rs_exp, input logic [31:0] rt_exp);
    sb_q.push_back({rs_exp, rt_exp});
    exp_fire = 1'b1;
  endtask

  task automatic tick();
    logic [63:0] e;
    @(posedge clock);
    #1;
    check("out_valid", {31'd0, out_valid}, {31'd0, exp_fire});
    if (out_valid === 1'b1) begin
      total++;
      assert (sb_q.size() != 0) else begin
        bad++;
        $error("FAIL sb_underflow observed=out_valid expected=no_output");
      end
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        check("rs_data", rs_data, e[63:32]);
        check("rt_data", rt_data, e[31:0]);
      end
    end
    exp_fire = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    exp_fire = 1'b0;
    idle();
    // A valid issue with a destination while held in reset must not take effect.
    issue_valid = 1; dest_en = 1; dest_addr = 5'd3; rs_addr = 5'd5;
    #2;
    check("rst_ready", {31'd0, issue_ready}, 32'd1);
    check("rst_b_ready", {31'd0, b_issue_ready}, 32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_rs_data", rs_data, 32'd0);
    check("rst_rt_data", rt_data, 32'd0);
    check("rst_count", {26'd0, pending_count}, 32'd0);
    tick();
    check("no_fire_in_reset", {26'd0, pending_count}, 32'd0);
    idle();
    reset = 1'b0;

    // No forwarding: the read waits one cycle past the write-back.
    b_issue_valid = 1; b_dest_en = 1; b_dest_addr = 5'd7;
    tick();
    check("b_fire_out_valid", {31'd0, b_out_valid}, 32'd1);
    check("b_count_set", {26'd0, b_pending_count}, 32'd1);
    b_dest_en = 0; b_rs_addr = 5'd7;
    #1 check("b_hazard_ready", {31'd0, b_issue_ready}, 32'd0);
    b_wb_en = 1; b_wb_addr = 5'd7; b_wb_data = 32'h0000_1234;
    #1 check("b_nobypass_ready", {31'd0, b_issue_ready}, 32'd0);
    tick();
    check("b_stall_out_valid", {31'd0, b_out_valid}, 32'd0);
    check("b_count_clear", {26'd0, b_pending_count}, 32'd0);
    b_wb_en = 0;
    #1 check("b_retry_ready", {31'd0, b_issue_ready}, 32'd1);
    tick();
    check("b_retry_out_valid", {31'd0, b_out_valid}, 32'd1);
    check("b_retry_rs_data", b_rs_data, 32'h0000_1234);
    check("b_retry_rt_data", b_rt_data, 32'd0);
    idle();

    // Write-back then read it back.
    wb_en = 1; wb_addr = 5'd5; wb_data = 32'hDEAD_BEEF;
    tick();
    wb_en = 0;
    issue_valid = 1; rs_addr = 5'd5; rt_addr = 5'd0;
    #1 check("read_ready", {31'd0, issue_ready}, 32'd1);
    expect_fire(32'hDEAD_BEEF, 32'd0);
    tick();
    issue_valid = 0;
    tick();
    check("hold_rs_data", rs_data, 32'hDEAD_BEEF);

    // RAW hazard on r7, resolved by a forwarded write-back.
    issue_valid = 1; rs_addr = 0; rt_addr = 0; dest_en = 1; dest_addr = 5'd7;
    expect_fire(32'd0, 32'd0);
    tick();
    check("count_after_dest7", {26'd0, pending_count}, 32'd1);
    dest_en = 0; rs_addr = 5'd7;
    #1 check("hazard_ready", {31'd0, issue_ready}, 32'd0);
    tick();
    check("stall_count", {26'd0, pending_count}, 32'd1);
    check("stall_ready", {31'd0, issue_ready}, 32'd0);
    wb_en = 1; wb_addr = 5'd7; wb_data = 32'h0000_1234;
    #1 check("bypass_ready", {31'd0, issue_ready}, 32'd1);
    expect_fire(32'h0000_1234, 32'd0);
    tick();
    check("count_after_wb7", {26'd0, pending_count}, 32'd0);
    wb_en = 0; rs_addr = 5'd7; rt_addr = 5'd5;
    expect_fire(32'h0000_1234, 32'hDEAD_BEEF);
    tick();

    // Set and clear of r9 in one cycle: set wins, storage still written.
    rs_addr = 0; rt_addr = 0; dest_en = 1; dest_addr = 5'd9;
    wb_en = 1; wb_addr = 5'd9; wb_data = 32'hAAAA_5555;
    expect_fire(32'd0, 32'd0);
    tick();
    check("set_wins_count", {26'd0, pending_count}, 32'd1);
    wb_en = 0; dest_addr = 5'd10;
    expect_fire(32'd0, 32'd0);
    tick();
    check("count_two", {26'd0, pending_count}, 32'd2);
    dest_addr = 5'd11;
    expect_fire(32'd0, 32'd0);
    tick();
    check("count_three", {26'd0, pending_count}, 32'd3);

    // Flush with a clean issue presented and a concurrent write-back to r12.
    dest_en = 0; rs_addr = 5'd10;
    #1 check("pre_flush_ready", {31'd0, issue_ready}, 32'd0);
    rs_addr = 0; flush = 1; wb_en = 1; wb_addr = 5'd12; wb_data = 32'hCAFE_F00D;
    #1 check("flush_cycle_ready", {31'd0, issue_ready}, 32'd1);
    tick();
    check("flush_count", {26'd0, pending_count}, 32'd0);
    flush = 0; wb_en = 0; rs_addr = 5'd10; rt_addr = 5'd9;
    #1 check("post_flush_ready", {31'd0, issue_ready}, 32'd1);
    expect_fire(32'd0, 32'hAAAA_5555);
    tick();
    rs_addr = 5'd12; rt_addr = 5'd11;
    expect_fire(32'hCAFE_F00D, 32'd0);
    tick();

    // Register 0: never pending, never written, never forwarded.
    rs_addr = 0; rt_addr = 0; dest_en = 1; dest_addr = 5'd0;
    wb_en = 1; wb_addr = 5'd0; wb_data = 32'hFFFF_FFFF;
    expect_fire(32'd0, 32'd0);
    tick();
    check("r0_count", {26'd0, pending_count}, 32'd0);
    dest_en = 0;
    expect_fire(32'd0, 32'd0);
    tick();
    wb_en = 0;

    // Reset in the middle of traffic discards pending state and the write-back.
    rs_addr = 5'd7; rt_addr = 5'd5; dest_en = 1; dest_addr = 5'd3;
    expect_fire(32'h0000_1234, 32'hDEAD_BEEF);
    tick();
    check("pre_reset_count", {26'd0, pending_count}, 32'd1);
    issue_valid = 0; dest_en = 0; wb_en = 1; wb_addr = 5'd4; wb_data = 32'h0000_0099;
    #2 reset = 1'b1;
    #1;
    check("midrst_count", {26'd0, pending_count}, 32'd0);
    check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    check("midrst_rs_data", rs_data, 32'd0);
    check("midrst_rt_data", rt_data, 32'd0);
    tick();
    reset = 1'b0; wb_en = 0;
    issue_valid = 1; rs_addr = 5'd4; rt_addr = 5'd3;
    #1 check("post_rst_ready", {31'd0, issue_ready}, 32'd1);
    expect_fire(32'd0, 32'd0);
    tick();
    rs_addr = 5'd7; rt_addr = 5'd5;
    expect_fire(32'd0, 32'd0);
    tick();
    idle();
    tick();
    check("sb_drained", sb_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/reg_read_scoreboard.md
REG_READ_SCOREBOARD -- requirements
Module: reg_read_scoreboard

Interface
REQ-001 SHALL have parameter BYPASS, default 1, meaning that when it is 1 a same-cycle write-back is forwarded to the read ports and clears the hazard.
REQ-002 SHALL have port clock, input, 1 bit: the single clock; all state changes on its posedge.
REQ-003 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port issue_valid, input, 1 bit: the decode stage presents an instruction for operand read.
REQ-005 SHALL have port issue_ready, output, 1 bit, combinational: no source hazard, so the read can fire.
REQ-006 SHALL have port rs_addr, input, 5 bits: first source register index.
REQ-007 SHALL have port rt_addr, input, 5 bits: second source register index.
REQ-008 SHALL have port dest_en, input, 1 bit: the issuing instruction will write a destination register.
REQ-009 SHALL have port dest_addr, input, 5 bits: destination register index.
REQ-010 SHALL have port wb_en, input, 1 bit: write-back strobe.
REQ-011 SHALL have port wb_addr, input, 5 bits: write-back register index.
REQ-012 SHALL have port wb_data, input, 32 bits: write-back value.
REQ-013 SHALL have port flush, input, 1 bit: squash the operand stage and clear the scoreboard.
REQ-014 SHALL have port out_valid, output, 1 bit, registered: rs_data and rt_data are valid.
REQ-015 SHALL have port rs_data, output, 32 bits, registered: first operand.
REQ-016 SHALL have port rt_data, output, 32 bits, registered: second operand.
REQ-017 SHALL have port pending_count, output, 6 bits, registered: number of set pending bits, 0 to 31.

Function
REQ-018 SHALL hold 32 x 32-bit registers and a 32-bit pending vector.
REQ-019 SHALL always read register 0 as 0, ignore writes to it, and never mark it pending.
REQ-020 SHALL define a source as hazarded when its index is nonzero and its pending bit is set, except where REQ-021 applies.
REQ-021 SHALL, when BYPASS is 1, treat a source as not hazarded when wb_en=1 and wb_addr equals that source's index; the source value is then wb_data.
REQ-022 SHALL drive issue_ready=1 exactly when neither rs nor rt is hazarded; issue_ready SHALL NOT depend on issue_valid.
REQ-023 SHALL define fire as issue_valid & issue_ready & ~flush.
REQ-024 SHALL, on fire, register the rs and rt values (storage, or bypass per REQ-021) into rs_data/rt_data and set out_valid=1 at the next edge, giving 1-cycle latency.
REQ-025 SHALL, in any cycle without fire, set out_valid=0 at the next edge and hold rs_data/rt_data.
REQ-026 SHALL, on fire with dest_en=1 and dest_addr!=0, set pending[dest_addr].
REQ-027 SHALL, on wb_en=1 with wb_addr!=0, write wb_data to storage and clear pending[wb_addr].
REQ-028 SHALL, when the set of REQ-026 and the clear of REQ-027 hit the same index in the same cycle, let the set win; the storage write still occurs.
REQ-029 SHALL, when BYPASS is 0, leave a source pending under a same-cycle write-back, so issue_ready=0 that cycle and the read retries next cycle.
REQ-030 SHALL, on flush=1, clear all pending bits and out_valid at the next edge and suppress fire; a concurrent write-back still updates storage.
REQ-031 SHALL update pending_count in the same edge as the pending vector changes.

Reset
REQ-032 SHALL, while reset=1, force asynchronously all storage registers to 0, pending to 0, out_valid=0, rs_data=0, rt_data=0 and pending_count=0.
REQ-033 SHALL keep issue_ready=1 during reset (all pending bits are 0), and SHALL NOT fire while reset is asserted.
REQ-034 SHALL, on reset asserted mid-operation, discard in-flight pending state and any write-back in that cycle.

Verification
REQ-035 SHALL cover: write-back r5=0xDEADBEEF, then issue rs=5, rt=0 -> next cycle out_valid=1, rs_data=0xDEADBEEF, rt_data=0.
REQ-036 SHALL cover: issue with dest=7, then issue with rs=7 -> issue_ready=0 and pending_count=1 until wb r7=0x1234; that cycle issue_ready=1 (BYPASS=1) and rs_data=0x1234.
REQ-037 SHALL cover: the same hazard with BYPASS=0 -> issue_ready rises only the cycle after the write-back.
REQ-038 SHALL cover: same-cycle fire with dest=9 and wb r9 -> pending[9] remains set and pending_count stays 1.
REQ-039 SHALL cover: three pending destinations, then flush=1 -> pending_count=0, out_valid=0, and a hazarded read is ready next cycle.
REQ-040 SHALL cover: issuing dest=0 and writing back r0=0xFFFFFFFF -> pending_count=0 and a subsequent read of r0 returns 0.
